// File: rtl/cam_sender.sv
// DVP camera sender: generates VSYNC/HREF framing and streams upstream bytes onto D0-D7.
// Optional CAM_SENDER_TESTPAT_EN adds an x^y test pattern selected by tp_sel.
module cam_sender #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        tp_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dout,
  output logic [31:0] frame_cnt,
  output logic        underflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP
  } state_t;

  localparam logic [10:0] H_LAST = 11'(H_BLANK + H_ACTIVE - 1);
  localparam logic [10:0] H_BLK  = 11'(H_BLANK);

  state_t      state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        stop_pend_q, stop_pend_d;
  logic        underflow_q, underflow_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  dout_q, dout_d;
  logic        tp_on;

  function automatic logic [9:0] last_line(input state_t s);
    case (s)
      S_VSYNC:  last_line = 10'(VSYNC_LINES - 1);
      S_VBP:    last_line = 10'(VBP_LINES - 1);
      S_ACTIVE: last_line = 10'(V_ACTIVE - 1);
      S_VFP:    last_line = 10'(VFP_LINES - 1);
      default:  last_line = 10'd0;
    endcase
  endfunction

`ifdef CAM_SENDER_TESTPAT_EN
  assign tp_on = tp_sel;
`else
  logic unused_tp_sel;
  assign unused_tp_sel = tp_sel;
  assign tp_on         = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    stop_pend_d = stop_pend_q | stop;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_VSYNC;
        hcnt_d  = 11'd0;
        vcnt_d  = 10'd0;
      end
    end else if (hcnt_q == H_LAST) begin
      hcnt_d = 11'd0;
      if (vcnt_q == last_line(state_q)) begin
        vcnt_d = 10'd0;
        case (state_q)
          S_VSYNC:  state_d = S_VBP;
          S_VBP:    state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFP;
          default: begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (stop_pend_q) begin
              state_d     = S_IDLE;
              stop_pend_d = stop;
            end else begin
              state_d = S_VSYNC;
            end
          end
        endcase
      end else begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    vsync_d     = (state_d == S_VSYNC);
    href_d      = (state_d == S_ACTIVE) && (hcnt_d >= H_BLK);
    in_ready    = href_d & ~tp_on;
    dout_d      = 8'h00;
    underflow_d = underflow_q;
    if (href_d) begin
      if (tp_on) begin
        dout_d = 8'(hcnt_d - H_BLK) ^ vcnt_d[7:0];
      end else if (in_valid) begin
        dout_d = in_data;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hcnt_q      <= 11'd0;
      vcnt_q      <= 10'd0;
      frame_cnt_q <= 32'd0;
      stop_pend_q <= 1'b0;
      underflow_q <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      dout_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
      stop_pend_q <= stop_pend_d;
      underflow_q <= underflow_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      dout_q      <= dout_d;
    end
  end

  assign vsync     = vsync_q;
  assign href      = href_q;
  assign dout      = dout_q;
  assign frame_cnt = frame_cnt_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_cam_sender.sv
// Bench for cam_sender on a small 8x4 frame; expected outputs come from frame-position arithmetic
// and a pixel queue filled by the bench's own handshake decisions.
module tb_cam_sender;
  localparam int HA = 8, HB = 4, VA = 4, VS = 1, VBPL = 1, VFPL = 1;
  localparam int L  = HA + HB;
  localparam int FL = (VS + VBPL + VA + VFPL) * L;
`ifdef CAM_SENDER_TESTPAT_EN
  localparam bit TP_EN = 1'b1;
`else
  localparam bit TP_EN = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0, tp_sel = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, vsync, href, underflow;
  logic [7:0]  dout;
  logic [31:0] frame_cnt;

  int checks = 0, failures = 0;
  int exp_fc = 0;
  bit exp_uf = 1'b0;
  logic [7:0] ramp = 8'h00;
  logic [7:0] pix_q[$];

  cam_sender #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
               .VSYNC_LINES(VS), .VBP_LINES(VBPL), .VFP_LINES(VFPL)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .tp_sel(tp_sel),
    .vsync(vsync), .href(href), .dout(dout), .frame_cnt(frame_cnt), .underflow(underflow));

  always #5 pclk = ~pclk;

  function automatic bit m_href(input int t);
    int ln = t / L;
    return (ln >= VS + VBPL) && (ln < VS + VBPL + VA) && ((t % L) >= HB);
  endfunction

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = 8'h00; tp_sel = 1'b0;
    step; step;
    rst_n = 1'b1;
    exp_fc = 0; exp_uf = 1'b0; ramp = 8'h00; pix_q.delete();
    step;
  endtask

  // Runs nframes from a start pulse; stop is pulsed at position stop_at of the last frame.
  task automatic run_frames(input int nframes, input int drop_t, input bit rnd,
                            input bit tp, input int stop_at);
    logic [7:0] exp_d, dv;
    bit exp_vs, exp_hr, exp_rdy, vld;
    tp_sel = tp;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int f = 0; f < nframes; f++) begin
      for (int t = 0; t < FL; t++) begin
        exp_vs  = (t / L) < VS;
        exp_hr  = m_href(t);
        exp_rdy = m_href(t + 1) && !(tp && TP_EN);
        exp_d   = 8'h00;
        if (exp_hr) begin
          if (tp && TP_EN) exp_d = 8'(((t % L) - HB) ^ ((t / L) - VS - VBPL));
          else if (pix_q.size() > 0) exp_d = pix_q.pop_front();
        end
        checks += 6;
        if (vsync !== exp_vs) begin failures++;
          $display("FAIL vsync f=%0d t=%0d got=%b exp=%b", f, t, vsync, exp_vs); end
        if (href !== exp_hr) begin failures++;
          $display("FAIL href f=%0d t=%0d got=%b exp=%b", f, t, href, exp_hr); end
        if (in_ready !== exp_rdy) begin failures++;
          $display("FAIL in_ready f=%0d t=%0d got=%b exp=%b", f, t, in_ready, exp_rdy); end
        if (dout !== exp_d) begin failures++;
          $display("FAIL dout f=%0d t=%0d got=%h exp=%h", f, t, dout, exp_d); end
        if (frame_cnt !== 32'(exp_fc)) begin failures++;
          $display("FAIL frame_cnt f=%0d t=%0d got=%0d exp=%0d", f, t, frame_cnt, exp_fc); end
        if (underflow !== exp_uf) begin failures++;
          $display("FAIL underflow f=%0d t=%0d got=%b exp=%b", f, t, underflow, exp_uf); end
        vld = rnd ? ($urandom_range(3) != 0) : (t != drop_t);
        dv  = rnd ? 8'($urandom) : ramp;
        in_valid = vld;
        in_data  = dv;
        start = rnd && ($urandom_range(7) == 0);
        stop  = (f == nframes - 1) && (t == stop_at);
        if (exp_rdy) begin
          pix_q.push_back(vld ? dv : 8'h00);
          if (vld) ramp++;
          else exp_uf = 1'b1;
        end
        step;
        if (t == FL - 1) exp_fc++;
      end
    end
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; tp_sel = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({vsync, href, in_ready, underflow, dout, frame_cnt} !== 44'd0) begin failures++;
      $display("FAIL reset_state got=%h exp=0", {vsync, href, in_ready, underflow, dout, frame_cnt}); end
    do_reset;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      checks++;
      if ({vsync, href, in_ready, underflow, dout, frame_cnt} !== 44'd0) begin failures++;
        $display("FAIL idle_outputs cyc=%0d got=%h exp=0", i,
                 {vsync, href, in_ready, underflow, dout, frame_cnt}); end
      step;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ramp;
    do_reset;
    run_frames(1, -1, 1'b0, 1'b0, 0);
    checks += 2;
    if (frame_cnt !== 32'd1) begin failures++;
      $display("FAIL ramp_frame_cnt got=%0d exp=1", frame_cnt); end
    if (underflow !== 1'b0) begin failures++;
      $display("FAIL ramp_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow;
    do_reset;
    run_frames(1, (VS + VBPL + 1) * L + HB + 2 - 1, 1'b0, 1'b0, 5);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (underflow !== 1'b1) begin failures++;
        $display("FAIL underflow_sticky cyc=%0d got=%b exp=1", i, underflow); end
      step;
    end
  endtask

  task automatic test_stop;
    do_reset;
    run_frames(1, -1, 1'b0, 1'b0, (VS + VBPL + 1) * L + 3);
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({vsync, href, in_ready} !== 3'b000 || frame_cnt !== 32'd1) begin failures++;
        $display("FAIL stop_idle cyc=%0d got=%b%b%b fc=%0d exp=000 fc=1",
                 i, vsync, href, in_ready, frame_cnt); end
      step;
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    run_frames(3, -1, 1'b1, 1'b0, $urandom_range(FL - 2));
    checks++;
    if (frame_cnt !== 32'd3) begin failures++;
      $display("FAIL b2b_frame_cnt got=%0d exp=3", frame_cnt); end
  endtask

  task automatic test_testpat;
    do_reset;
    run_frames(1, -1, 1'b0, 1'b1, 7);
    checks++;
    if (underflow !== 1'b0) begin failures++;
      $display("FAIL testpat_underflow got=%b exp=0", underflow); end
  endtask

  task automatic test_midframe_reset;
    do_reset;
    in_valid = 1'b1;
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (30) step;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({vsync, href, in_ready, underflow, dout, frame_cnt} !== 44'd0) begin failures++;
      $display("FAIL async_reset got=%h exp=0", {vsync, href, in_ready, underflow, dout, frame_cnt}); end
    step;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (vsync !== 1'b0 || href !== 1'b0 || frame_cnt !== 32'd0) begin failures++;
        $display("FAIL post_reset_idle cyc=%0d vsync=%b href=%b fc=%0d exp=0,0,0",
                 i, vsync, href, frame_cnt); end
      step;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_underflow;
    test_stop;
    test_back_to_back;
    test_testpat;
    test_midframe_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_sender.md
CAM_SENDER -- requirements
Module: cam_sender

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels (pclk cycles with href=1) per line.
REQ-002 Parameter H_BLANK, default 144, href-low cycles per line; line length L = H_BLANK+H_ACTIVE.
REQ-003 Parameters V_ACTIVE (480), VSYNC_LINES (3), VBP_LINES (17), VFP_LINES (10), line counts per frame region.
REQ-004 pclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins frame generation from IDLE.
REQ-007 stop  in  1  single-cycle pulse; requests return to IDLE after the current frame completes.
REQ-008 in_data  in  8  raw pixel byte from the upstream stream.
REQ-009 in_valid  in  1  in_data valid.
REQ-010 in_ready  out  1  cam_sender accepts in_data this cycle.
REQ-011 tp_sel  in  1  selects the internal test pattern (used only with CAM_SENDER_TESTPAT_EN).
REQ-012 vsync  out  1  DVP VSYNC, active high, registered.
REQ-013 href  out  1  DVP HREF, active high, registered.
REQ-014 dout  out  8  DVP D0-D7, registered.
REQ-015 frame_cnt  out  32  completed frames; wraps modulo 2^32.
REQ-016 underflow  out  1  sticky; set when an active pixel had no valid input.

Function
REQ-017 States: IDLE, VSYNC, VBP, ACTIVE, VFP; each non-IDLE state lasts (its line count) x L cycles, counted by hcnt (0..L-1) and vcnt.
REQ-018 IDLE -> VSYNC on the cycle after start=1; start is ignored outside IDLE.
REQ-019 VSYNC -> VBP -> ACTIVE -> VFP in sequence; VFP -> VSYNC, or VFP -> IDLE if stop_pend=1.
REQ-020 vsync=1 during every cycle of VSYNC state and 0 otherwise.
REQ-021 In ACTIVE, each line: href=0 for hcnt 0..H_BLANK-1, href=1 for hcnt H_BLANK..L-1; href=0 in all other states.
REQ-022 in_ready is combinational and equals 1 in cycle N exactly when href will be 1 in cycle N+1.
REQ-023 In each in_ready cycle: if in_valid=1, dout <= in_data; else dout <= 8'h00 and underflow <= 1.
REQ-024 dout <= 8'h00 whenever href will be 0 in the next cycle.
REQ-025 Underflow never alters vsync/href timing; a line always carries exactly H_ACTIVE href-high cycles.
REQ-026 stop sets stop_pend (also in IDLE, or in the same cycle as start); stop_pend clears on entry to IDLE.
REQ-027 frame_cnt increments by 1 on the final cycle of VFP, whether the next state is VSYNC or IDLE.
REQ-028 underflow clears only on reset.
REQ-029 hcnt is 11 bits and vcnt 10 bits; parameters exceeding these widths are unsupported.

Reset
REQ-030 On rst_n=0, immediately: state=IDLE, vsync=0, href=0, dout=8'h00, in_ready=0, frame_cnt=0, underflow=0, stop_pend=0, hcnt=0, vcnt=0.
REQ-031 Reset mid-frame abandons the frame with no completion; generation resumes only after a new start.

Configuration
REQ-032 Macro CAM_SENDER_TESTPAT_EN defined: when tp_sel=1, an active pixel's dout = (pixel x-index[7:0]) XOR (active line index[7:0]), in_ready=0, and underflow is not set.
REQ-033 Macro CAM_SENDER_TESTPAT_EN undefined: no pattern logic; tp_sel is ignored and all pixels come from in_data.

Verification
(Scenarios 1-5 use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, so L=12.)
REQ-034 Reset, then no start for 100 cycles -> all outputs 0 throughout.
REQ-035 start pulse, in_valid=1, in_data ramp 0,1,2,... -> vsync high 12 cycles; 4 lines of href high 8 cycles; dout 0..31 in order; frame_cnt=1 after 84 cycles.
REQ-036 in_valid=0 for the 3rd pixel of line 2 -> dout=8'h00 that cycle, underflow=1 and stays 1, href pattern unchanged.
REQ-037 stop pulsed during the 2nd line of ACTIVE -> frame completes, frame_cnt=1, then IDLE with vsync=0 indefinitely.
REQ-038 Default parameters looped back into the team's camera receiver, 3 frames -> receiver hlen=0 and vlen=0 (no mismatch), sender frame_cnt=3.
REQ-039 CAM_SENDER_TESTPAT_EN defined, tp_sel=1 -> line 1 pixel 5 dout=8'h04; in_ready stays 0; underflow stays 0.
